// File: rtl/uart_echo_engine.sv
// UART echo engine: receive, transform, buffer, retransmit, with XON/XOFF pause and sticky overflow.
// Define UART_ECHO_STATS_EN to add the rx_byte_count / tx_byte_count ports.

// Generic synchronous FIFO with first-word-fall-through read data.
// Latency: enqueued word is visible at deq_dat one cycle after the enqueue edge.
// Backpressure: enq_rdy drops when full; deq_vld drops when empty.
module fifo #(
    parameter int WIDTH    = 8,
    parameter int LOGDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_vld,
    output logic             enq_rdy,
    input  logic [WIDTH-1:0] enq_dat,
    output logic             deq_vld,
    input  logic             deq_rdy,
    output logic [WIDTH-1:0] deq_dat
);
    localparam int DEPTH = 1 << LOGDEPTH;
    localparam int AW    = (LOGDEPTH > 0) ? LOGDEPTH : 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LOGDEPTH:0] count;
    logic              do_enq;
    logic              do_deq;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign enq_rdy = (count != (LOGDEPTH + 1)'(DEPTH));
    assign deq_vld = (count != '0);
    assign deq_dat = mem[rd_ptr];
    assign do_enq  = enq_vld && enq_rdy;
    assign do_deq  = deq_vld && deq_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= next_ptr(wr_ptr);
            if (do_deq) rd_ptr <= next_ptr(rd_ptr);
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_dat;
    end
endmodule

// UART receiver, 8N1, mid-bit sampling behind a two-flop synchronizer.
// Latency: data_out_valid rises one cycle after the middle of the stop bit.
// Backpressure: data_out_valid holds until data_out_ready; a newer byte overwrites it.
module uart_receiver #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    dat_nxt;
    logic          vld_nxt;
    logic [1:0]    sync;
    logic          rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RX_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            sync           <= 2'b11;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bit_idx        <= bit_idx_nxt;
            shreg          <= shreg_nxt;
            sync           <= {sync[0], serial_in};
            data_out       <= dat_nxt;
            data_out_valid <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        dat_nxt     = data_out;
        vld_nxt     = data_out_valid && !data_out_ready;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (cnt == CW'(CPB / 2 - 1)) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(CPB - 1)) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(CPB - 1)) begin
                    state_nxt = RX_IDLE;
                    if (rx_s) begin
                        vld_nxt = 1'b1;
                        dat_nxt = shreg;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end
endmodule

// UART transmitter, 8N1, registered line output.
// Latency: start bit appears on serial_out on the edge that accepts the byte.
// Backpressure: data_in_ready is high only while idle, i.e. once per full frame.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);

    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    tx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [8:0]    shreg, shreg_nxt;
    logic          line_nxt;

    assign data_in_ready = (state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '1;
            serial_out <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            serial_out <= line_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        line_nxt  = serial_out;
        case (state)
            TX_IDLE: begin
                line_nxt = 1'b1;
                if (data_in_valid) begin
                    shreg_nxt = {1'b1, data_in};
                    line_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // idx counts finished bit periods; period 9 is the stop bit.
                if (cnt == CW'(CPB - 1)) begin
                    cnt_nxt = '0;
                    if (idx == 4'd9) begin
                        state_nxt = TX_IDLE;
                    end else begin
                        line_nxt  = shreg[0];
                        shreg_nxt = {1'b1, shreg[8:1]};
                        idx_nxt   = idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end
endmodule

// Echo top: RX -> flow-control filter -> case transform stage -> FIFO -> TX.
// Latency: byte enqueued 2 edges after RX valid; TX start up to 4 cycles later when idle.
// Backpressure: none toward RX (bytes dropped when full, overflow sticky); XOFF holds dequeue.
module uart_echo_engine #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int LOGDEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    output logic                serial_out,
    input  logic [1:0]          mode,
    input  logic                xonxoff_en,
    input  logic                clear_overflow,
    output logic                tx_paused,
    output logic                overflow,
    output logic [LOGDEPTH:0]   fifo_count
`ifdef UART_ECHO_STATS_EN
    ,
    output logic [15:0]         rx_byte_count,
    output logic [15:0]         tx_byte_count
`endif
);
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       is_ctrl;
    logic       stage_vld;
    logic [7:0] stage_dat;
    logic       enq_rdy;
    logic       enq;
    logic       drop;
    logic       deq_vld;
    logic [7:0] deq_dat;
    logic       tx_rdy;
    logic       deq;

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
        logic upper;
        logic lower;
        upper = (b >= 8'h41) && (b <= 8'h5A);
        lower = (b >= 8'h61) && (b <= 8'h7A);
        case (m)
            2'b01:   return (upper || lower) ? (b ^ 8'h20) : b;
            2'b10:   return lower ? (b & 8'hDF) : b;
            2'b11:   return upper ? (b | 8'h20) : b;
            default: return b;
        endcase
    endfunction

    uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk(clk), .rst(rst), .serial_in(serial_in),
        .data_out(rx_dat), .data_out_valid(rx_vld), .data_out_ready(1'b1)
    );

    fifo #(.WIDTH(8), .LOGDEPTH(LOGDEPTH)) u_fifo (
        .clk(clk), .rst(rst),
        .enq_vld(stage_vld), .enq_rdy(enq_rdy), .enq_dat(stage_dat),
        .deq_vld(deq_vld), .deq_rdy(tx_rdy && !tx_paused), .deq_dat(deq_dat)
    );

    uart_transmitter #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk(clk), .rst(rst), .data_in(deq_dat), .data_in_valid(deq_vld && !tx_paused),
        .data_in_ready(tx_rdy), .serial_out(serial_out)
    );

    assign is_ctrl = xonxoff_en && ((rx_dat == 8'h11) || (rx_dat == 8'h13));
    assign enq     = stage_vld && enq_rdy;
    assign drop    = stage_vld && !enq_rdy;
    assign deq     = deq_vld && tx_rdy && !tx_paused;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_paused  <= 1'b0;
            stage_vld  <= 1'b0;
            stage_dat  <= '0;
            overflow   <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (!xonxoff_en)                     tx_paused <= 1'b0;
            else if (rx_vld && rx_dat == 8'h13) tx_paused <= 1'b1;
            else if (rx_vld && rx_dat == 8'h11) tx_paused <= 1'b0;
            stage_vld <= rx_vld && !is_ctrl;
            if (rx_vld) stage_dat <= xform(rx_dat, mode);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef UART_ECHO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte_count <= '0;
            tx_byte_count <= '0;
        end else begin
            if (rx_vld) rx_byte_count <= rx_byte_count + 16'd1;
            if (deq)    tx_byte_count <= tx_byte_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_echo_engine.sv
// Scoreboard bench for uart_echo_engine: UART driver on serial_in, UART monitor on serial_out.
module tb_uart_echo_engine;
    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int CPB = CF / BR;
    localparam int LD  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic          serial_out;
    logic [1:0]    mode;
    logic          xonxoff_en;
    logic          clear_overflow;
    logic          tx_paused;
    logic          overflow;
    logic [LD:0]   fifo_count;
`ifdef UART_ECHO_STATS_EN
    logic [15:0]   rx_byte_count;
    logic [15:0]   tx_byte_count;
`endif

    int            total = 0;
    int            bad   = 0;
    logic          mon_en;
    logic [7:0]    mon_b;
    logic [7:0]    exp_q[$];

    always #5 clk = ~clk;

    uart_echo_engine #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .LOGDEPTH(LD)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(serial_out),
        .mode(mode), .xonxoff_en(xonxoff_en), .clear_overflow(clear_overflow),
        .tx_paused(tx_paused), .overflow(overflow), .fifo_count(fifo_count)
`ifdef UART_ECHO_STATS_EN
        , .rx_byte_count(rx_byte_count), .tx_byte_count(tx_byte_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_exp(input logic [7:0] b, input logic [7:0] e);
        exp_q.push_back(e);
        send_byte(b);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2 * CPB) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    // Line monitor: decodes frames on serial_out and checks them against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en === 1'b1 && rst === 1'b0 && serial_out === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = serial_out;
                end
                repeat (CPB) @(negedge clk);
                chk("stop_bit", serial_out, 1);
                if (exp_q.size() == 0) chk("unexpected_byte", mon_b, 32'h100);
                else                   chk("echo_byte", mon_b, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lows;
        rst = 1'b1; serial_in = 1'b1; mode = 2'b00; xonxoff_en = 1'b0;
        clear_overflow = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_line", serial_out, 1);
        chk("rst_paused", tx_paused, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        mode = 2'b01;
        send_exp(8'h61, 8'h41); send_exp(8'h5A, 8'h7A); send_exp(8'h35, 8'h35);
        wait_drain();
        chk("toggle_count", fifo_count, 0);

        mode = 2'b10;
        send_exp(8'h61, 8'h41); send_exp(8'h42, 8'h42); send_exp(8'h7B, 8'h7B);
        mode = 2'b11;
        send_exp(8'h61, 8'h61); send_exp(8'h42, 8'h62); send_exp(8'h7B, 8'h7B);
        wait_drain();

        // XOFF holds the queue, XON releases it.
        xonxoff_en = 1'b1; mode = 2'b00;
        send_byte(8'h13);
        chk("xoff_paused", tx_paused, 1);
        send_exp(8'h78, 8'h78); send_exp(8'h79, 8'h79);
        lows = 0;
        repeat (4 * CPB) begin
            @(negedge clk);
            if (serial_out == 1'b0) lows++;
        end
        chk("idle_while_paused", lows, 0);
        chk("paused_count", fifo_count, 2);
        send_byte(8'h11);
        chk("xon_unpaused", tx_paused, 0);
        wait_drain();
        chk("xon_count", fifo_count, 0);

        // Overflow with depth 4 while paused.
        send_byte(8'h13);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_q.push_back(8'h30 + 8'(k));
            send_byte(8'h30 + 8'(k));
        end
        chk("full_count", fifo_count, 4);
        chk("overflow_set", overflow, 1);
        @(negedge clk) clear_overflow = 1'b1;
        @(negedge clk) clear_overflow = 1'b0;
        chk("overflow_cleared", overflow, 0);
        fork
            send_byte(8'h37);
            begin
                clear_overflow = 1'b1;
                for (int i = 0; i < 12 * CPB; i++) begin
                    @(negedge clk);
                    if (overflow) break;
                end
                clear_overflow = 1'b0;
            end
        join
        chk("drop_beats_clear", overflow, 1);
        chk("full_count_after_drop", fifo_count, 4);
        send_byte(8'h11);
        wait_drain();

        // Disabling flow control releases a pause on the next edge.
        send_byte(8'h13);
        chk("repause", tx_paused, 1);
        @(negedge clk) xonxoff_en = 1'b0;
        @(negedge clk);
        chk("disable_unpauses", tx_paused, 0);

        send_exp(8'h13, 8'h13);
        chk("plain_xoff_no_pause", tx_paused, 0);
        wait_drain();

        // Reset in the middle of an outgoing frame (data bit 1 of 0x55 is low).
        mon_en = 1'b0;
        send_byte(8'h55);
        repeat (2 * CPB + CPB / 2) @(negedge clk);
        chk("mid_tx_line", serial_out, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_line", serial_out, 1);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_paused", tx_paused, 0);
        chk("rst_mid_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        mon_en = 1'b1;

        send_exp(8'h41, 8'h41); send_exp(8'h42, 8'h42); send_exp(8'h43, 8'h43);
        wait_drain();
`ifdef UART_ECHO_STATS_EN
        chk("rx_byte_count", rx_byte_count, 3);
        chk("tx_byte_count", tx_byte_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
